digest_hex_tx: RTL and testbench

//  Downstream of the BLAKE2 data manager. Captures one digest byte stream
//  (W bytes, LSB-of-h first, one byte per cycle, no backpressure) into a local

---
 rtl/digest_hex_tx.sv | 172 +++++++++++++++++
 tb/tb_digest_hex_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/digest_hex_tx.sv
// Captures one W-byte digest from the data manager and replays it as ASCII hex
// over a valid/ready byte stream, optionally terminated by a newline.
module digest_hex_tx #(
  parameter int unsigned W       = 32,
  parameter bit          NEWLINE = 1'b1,
  parameter bit          UPPER   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_end,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun,
  output logic       length_err,
  input  logic       clr_err
);

  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned CW = BW + 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(W - 1);
  localparam logic [CW-1:0] LAST_CHR  = CW'(2 * W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEND, S_NL} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_buf [W];
  logic [BW-1:0]   r_wr_idx;
  logic [CW-1:0]   r_chr_idx;
  logic            r_skip, w_skip_nxt;
  logic            r_overrun, r_length_err;
  logic            r_tx_valid;
  logic [7:0]      r_tx_data;

  logic            w_wr_en, w_start, w_adv, w_set_len, w_set_ovr;
  logic [BW-1:0]   w_wr_addr;
  logic [CW-1:0]   w_nxt_chr;
  logic [7:0]      w_nxt_byte, w_first_byte;
  logic [3:0]      w_nxt_nib;

  function automatic logic [7:0] hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return (UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  assign w_wr_addr    = (r_state == S_IDLE) ? '0 : r_wr_idx;
  assign w_nxt_chr    = r_chr_idx + CW'(1);
  assign w_nxt_byte   = r_buf[w_nxt_chr[CW-1:1]];
  assign w_nxt_nib    = w_nxt_chr[0] ? w_nxt_byte[3:0] : w_nxt_byte[7:4];
  // A single-byte digest starts sending in the cycle its only byte arrives.
  assign w_first_byte = (W == 1) ? din : r_buf[0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_wr_en     = 1'b0;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_set_len   = 1'b0;
    w_set_ovr   = 1'b0;
    if (din_valid && din_end) w_skip_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (din_valid && !r_skip) begin
          if (W == 1) begin
            w_wr_en = 1'b1;
            if (din_end) begin
              w_state_nxt = S_SEND;
              w_start     = 1'b1;
            end else begin
              w_set_len  = 1'b1;
              w_skip_nxt = 1'b1;
            end
          end else if (din_end) begin
            w_set_len = 1'b1;
          end else begin
            w_wr_en     = 1'b1;
            w_state_nxt = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (din_valid) begin
          w_wr_en = 1'b1;
          if (din_end) begin
            if (r_wr_idx == LAST_BYTE) begin
              w_state_nxt = S_SEND;
              w_start     = 1'b1;
            end else begin
              w_set_len   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else if (r_wr_idx == LAST_BYTE) begin
            w_set_len   = 1'b1;
            w_skip_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_SEND: begin
        if (din_valid) begin
          w_set_ovr = 1'b1;
          if (!din_end) w_skip_nxt = 1'b1;
        end
        if (r_tx_valid && tx_ready) begin
          if (r_chr_idx == LAST_CHR) w_state_nxt = NEWLINE ? S_NL : S_IDLE;
          else                       w_adv = 1'b1;
        end
      end
      S_NL: begin
        if (din_valid) begin
          w_set_ovr = 1'b1;
          if (!din_end) w_skip_nxt = 1'b1;
        end
        if (r_tx_valid && tx_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_wr_addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_idx     <= '0;
      r_chr_idx    <= '0;
      r_skip       <= 1'b0;
      r_overrun    <= 1'b0;
      r_length_err <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_tx_valid <= (w_state_nxt == S_SEND) || (w_state_nxt == S_NL);
      if (w_start) begin
        r_chr_idx <= '0;
        r_tx_data <= hex(w_first_byte[7:4]);
      end else if (w_adv) begin
        r_chr_idx <= w_nxt_chr;
        r_tx_data <= hex(w_nxt_nib);
      end else if (r_state == S_SEND && w_state_nxt == S_NL) begin
        r_tx_data <= 8'h0A;
      end
      if (w_state_nxt != S_CAPTURE) r_wr_idx <= '0;
      else if (w_wr_en)             r_wr_idx <= (r_state == S_IDLE) ? BW'(1) : r_wr_idx + BW'(1);
      r_skip <= w_skip_nxt;
      // Set events are applied after the clear so they win in the same cycle.
      if (clr_err) begin
        r_overrun    <= 1'b0;
        r_length_err <= 1'b0;
      end
      if (w_set_ovr) r_overrun    <= 1'b1;
      if (w_set_len) r_length_err <= 1'b1;
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign busy       = (r_state != S_IDLE);
  assign overrun    = r_overrun;
  assign length_err = r_length_err;

endmodule

// File: tb/tb_digest_hex_tx.sv
// Directed bench for digest_hex_tx: one lowercase+newline instance and one
// uppercase/no-terminator instance sharing the capture-side inputs.
module tb_digest_hex_tx;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0, din_end = 1'b0, clr_err = 1'b0;
  logic       tx_ready0 = 1'b1, tx_ready1 = 1'b1;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1, busy0, busy1;
  logic       overrun0, overrun1, length_err0, length_err1;

  int errors = 0, checks = 0, last_cyc = 0;
  int viol0 = 0, stalls0 = 0;
  bit stall0 = 1'b0;
  logic [7:0] hold0 = '0;
  bq_t q0, q1, dA, dB, dC, dAB, d5;

  always #5 clk = ~clk;

  digest_hex_tx #(.W(32), .NEWLINE(1'b1), .UPPER(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_end(din_end),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .busy(busy0),
    .overrun(overrun0), .length_err(length_err0), .clr_err(clr_err));

  digest_hex_tx #(.W(32), .NEWLINE(1'b0), .UPPER(1'b1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_end(din_end),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .busy(busy1),
    .overrun(overrun1), .length_err(length_err1), .clr_err(clr_err));

  // Record accepted characters and watch tx_data across stalls.
  always @(posedge clk) begin
    if (tx_valid0 && tx_ready0) q0.push_back(tx_data0);
    if (stall0 && tx_valid0 && tx_data0 !== hold0) viol0++;
    if (tx_valid0 && !tx_ready0) stalls0++;
    stall0 = tx_valid0 && !tx_ready0;
    hold0  = tx_data0;
    if (tx_valid1 && tx_ready1) q1.push_back(tx_data1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input bq_t b, input bit with_end);
    foreach (b[i]) begin
      din       = b[i];
      din_valid = 1'b1;
      din_end   = with_end && (i == b.size() - 1);
      tick();
    end
    din_valid = 1'b0;
    din_end   = 1'b0;
    din       = '0;
  endtask

  task automatic wait_q(input bit sel, input int n, input int budget, input bit rnd);
    int cyc = 0;
    while (((sel ? q1.size() : q0.size()) < n) && cyc < budget) begin
      if (rnd) tx_ready0 = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    tx_ready0 = 1'b1;
    check("wait_chars", 32'((sel ? q1.size() : q0.size()) >= n), 32'd1);
    last_cyc = cyc;
  endtask

  function automatic bq_t hexs(input bq_t b, input bit upper, input bit nl);
    string digits;
    bq_t   e;
    digits = upper ? "0123456789ABCDEF" : "0123456789abcdef";
    foreach (b[i]) begin
      e.push_back(digits[b[i][7:4]]);
      e.push_back(digits[b[i][3:0]]);
    end
    if (nl) e.push_back(8'h0A);
    return e;
  endfunction

  task automatic cmp(input string tag, input bq_t got, input bq_t exp);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      dA.push_back(8'(i));
      dB.push_back(8'(8'h80 + i));
      dC.push_back(8'(i * 7 + 3));
      dAB.push_back(8'hAB);
    end
    for (int i = 0; i < 5; i++) d5.push_back(8'(8'h40 + i));

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    check("rst_tx_valid", tx_valid0, 1'b0);
    check("rst_tx_data", tx_data0, 8'h00);
    check("rst_busy", busy0, 1'b0);
    check("rst_overrun", overrun0, 1'b0);
    check("rst_length_err", length_err0, 1'b0);
    tick();

    // 1: contiguous 00..1F, sink always ready
    q0.delete();
    feed(dA, 1'b1);
    check("t1_first_valid", tx_valid0, 1'b1);
    check("t1_first_char", tx_data0, 8'h30);
    check("t1_busy", busy0, 1'b1);
    wait_q(1'b0, 65, 300, 1'b0);
    check("t1_cycles", last_cyc, 65);
    check("t1_valid_after", tx_valid0, 1'b0);
    cmp("t1_chars", q0, hexs(dA, 1'b0, 1'b1));
    check("t1_overrun", overrun0, 1'b0);
    check("t1_length_err", length_err0, 1'b0);
    tick();

    // 2: same digest, sink ready toggled randomly
    q0.delete();
    viol0 = 0;
    stalls0 = 0;
    feed(dA, 1'b1);
    wait_q(1'b0, 65, 2000, 1'b1);
    repeat (3) tick();
    cmp("t2_chars", q0, hexs(dA, 1'b0, 1'b1));
    check("t2_stable", viol0, 0);
    check("t2_stalls_seen", 32'(stalls0 > 0), 32'd1);

    // 3: uppercase, no newline terminator
    q0.delete();
    q1.delete();
    feed(dAB, 1'b1);
    wait_q(1'b1, 64, 300, 1'b0);
    repeat (5) tick();
    check("t3_no_nl", q1.size(), 64);
    check("t3_valid_after", tx_valid1, 1'b0);
    cmp("t3_chars", q1, hexs(dAB, 1'b1, 1'b0));

    // 4: second digest arrives during SEND (start of stream, then near its end)
    for (int k = 0; k < 2; k++) begin
      pulse_clr();
      check("t4_ovr_cleared", overrun0, 1'b0);
      q0.delete();
      feed(dA, 1'b1);
      wait_q(1'b0, (k == 0) ? 10 : 55, 300, 1'b0);
      feed(dB, 1'b1);
      wait_q(1'b0, 65, 300, 1'b0);
      repeat (20) tick();
      cmp($sformatf("t4_first_%0d", k), q0, hexs(dA, 1'b0, 1'b1));
      check("t4_overrun", overrun0, 1'b1);
      check("t4_idle", busy0, 1'b0);
      q0.delete();
      feed(dC, 1'b1);
      wait_q(1'b0, 65, 300, 1'b0);
      cmp($sformatf("t4_third_%0d", k), q0, hexs(dC, 1'b0, 1'b1));
    end

    // 5: short digest -> length error, then recovery
    pulse_clr();
    check("t5_len_clear0", length_err0, 1'b0);
    q0.delete();
    feed(d5, 1'b1);
    repeat (10) tick();
    check("t5_no_output", q0.size(), 0);
    check("t5_tx_valid", tx_valid0, 1'b0);
    check("t5_busy", busy0, 1'b0);
    check("t5_length_err", length_err0, 1'b1);
    pulse_clr();
    check("t5_len_cleared", length_err0, 1'b0);
    feed(dC, 1'b1);
    wait_q(1'b0, 65, 300, 1'b0);
    cmp("t5_next", q0, hexs(dC, 1'b0, 1'b1));
    tick();

    // 6: reset mid-SEND
    q0.delete();
    feed(dA, 1'b1);
    wait_q(1'b0, 5, 100, 1'b0);
    din = 8'h77;
    din_valid = 1'b1;
    din_end = 1'b1;
    tick();
    din_valid = 1'b0;
    din_end = 1'b0;
    wait_q(1'b0, 20, 100, 1'b0);
    check("t6_ovr_before", overrun0, 1'b1);
    rst = 1'b1;
    tick();
    check("t6_tx_valid", tx_valid0, 1'b0);
    check("t6_busy", busy0, 1'b0);
    check("t6_overrun", overrun0, 1'b0);
    check("t6_length_err", length_err0, 1'b0);
    check("t6_tx_data", tx_data0, 8'h00);
    rst = 1'b0;
    tick();
    q0.delete();
    feed(dB, 1'b1);
    check("t6_first_char", tx_data0, 8'h38);
    wait_q(1'b0, 65, 300, 1'b0);
    cmp("t6_after", q0, hexs(dB, 1'b0, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
